// File: rtl/seq_mult4_pkg.sv
// Shared types and sizing for the seq_mult4 shift-and-add multiplier.
package seq_mult4_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam int N_ITER = 4;
  localparam int P_W    = 8;

endpackage

// File: rtl/ADDER4_2.sv
// 4-bit ripple-carry adder shared by seq_mult4 for its per-cycle partial-product add.
module ADDER4_2 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[4];

endmodule

// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier built around one ADDER4_2.
// Define SEQ_MULT4_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult4
  import seq_mult4_pkg::*;
#(
  parameter int DONE_PULSE = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [3:0]     A,
  input  logic [3:0]     B,
  output logic           BUSY,
  output logic           DONE,
  output logic [P_W-1:0] P
);

  state_t         state_q, state_d;
  logic [3:0]     mcand_q, mcand_d;
  logic [8:0]     acc_q, acc_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [P_W-1:0] p_q, p_d;
  logic           done_q, done_d;

  logic [3:0] addB;
  logic [3:0] addS;
  logic       addCout;
  logic [8:0] stepAcc;

  assign addB = acc_q[0] ? mcand_q : 4'b0000;

  ADDER4_2 u_adder (
    .A    (acc_q[7:4]),
    .B    (addB),
    .Cin  (1'b0),
    .S    (addS),
    .Cout (addCout)
  );

  // Splice the adder result into the top of ACC, then shift the whole word right by one.
  always_comb begin
    stepAcc      = acc_q;
    stepAcc[8:4] = {addCout, addS};
    stepAcc      = stepAcc >> 1;
  end

`ifdef SEQ_MULT4_EARLY_TERM_EN
  logic [3:0] remMask;
  logic [2:0] remIter;

  assign remMask = 4'hF >> cnt_q;
  assign remIter = 3'(N_ITER) - {1'b0, cnt_q};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = (DONE_PULSE != 0) ? 1'b0 : done_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          mcand_d = A;
          acc_d   = {5'b00000, B};
          cnt_d   = 2'd0;
          done_d  = 1'b0;
          state_d = CALC;
        end
      end

      CALC: begin
        acc_d = stepAcc;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(N_ITER - 1)) begin
          state_d = FIN;
        end
`ifdef SEQ_MULT4_EARLY_TERM_EN
        // No set multiplier bits left: the remaining iterations are pure shifts.
        if ((acc_q[3:0] & remMask) == 4'b0000) begin
          acc_d   = acc_q >> remIter;
          state_d = FIN;
        end
`endif
      end

      FIN: begin
        p_d     = acc_q[7:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state_q == CALC);
  assign DONE = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_seq_mult4.sv
// Directed bench for seq_mult4: a pulse-DONE instance and a level-DONE instance share stimulus.
// Build with SEQ_MULT4_EARLY_TERM_EN to expect data-dependent CALC length.
module tb_seq_mult4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;

  logic       BUSY, DONE;
  logic [7:0] P;
  logic       busyLvl, doneLvl;
  logic [7:0] pLvl;

  int compareCount  = 0;
  int mismatchCount = 0;

  seq_mult4 #(.DONE_PULSE(1)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .P(P)
  );

  seq_mult4 #(.DONE_PULSE(0)) dutLvl (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .BUSY(busyLvl), .DONE(doneLvl), .P(pLvl)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Number of CALC cycles the design should spend for multiplier b.
  function automatic int expCalc(input logic [3:0] b);
`ifdef SEQ_MULT4_EARLY_TERM_EN
    for (int c = 0; c < 4; c++) begin
      if ((b >> c) == 4'd0) return c + 1;
    end
    return 4;
`else
    return 4;
`endif
  endfunction

  // Count BUSY cycles, step through FIN, and land in the cycle where DONE should be high.
  task automatic waitDone(output int calc);
    calc = 0;
    while (BUSY && calc < 20) begin
      calc++;
      tick();
    end
    if (calc >= 20) checkOutput("busyBound", calc, 4);
    checkOutput("finNoDone", int'(DONE), 0);
    tick();
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int expP);
    int calc;
    START = 1'b1; A = a; B = b;
    tick();
    START = 1'b0;
    checkOutput("busyAfterStart", int'(BUSY), 1);
    waitDone(calc);
    checkOutput("calcCycles", calc, expCalc(b));
    checkOutput("doneHigh", int'(DONE), 1);
    checkOutput("product", int'(P), expP);
  endtask

  initial begin
    int calc;

    // Reset then idle
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    checkOutput("rstBusy", int'(BUSY), 0);
    checkOutput("rstDone", int'(DONE), 0);
    checkOutput("rstP", int'(P), 0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("idleBusy", int'(BUSY), 0);
    checkOutput("idleDone", int'(DONE), 0);
    checkOutput("idleLvlDone", int'(doneLvl), 0);

    // 13 * 11, then DONE pulse vs level behaviour
    applyStimulus(4'd13, 4'd11, 143);
    checkOutput("lvlDoneHigh", int'(doneLvl), 1);
    checkOutput("lvlProduct", int'(pLvl), 143);
    tick();
    checkOutput("pulseDoneLow", int'(DONE), 0);
    checkOutput("pulsePHeld", int'(P), 143);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("lvlDoneHeld", int'(doneLvl), 1);
    START = 1'b1; A = 4'd1; B = 4'd1;
    tick();
    START = 1'b0;
    checkOutput("lvlDoneCleared", int'(doneLvl), 0);
    checkOutput("lvlBusy", int'(busyLvl), 1);
    waitDone(calc);
    checkOutput("oneTimesOne", int'(P), 1);

    // All 256 operand pairs back to back; includes 15 * 15 = 225
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), a * b);
      end
    end
    checkOutput("maxProduct", int'(P), 225);

    // START held high with changing operands while busy
    START = 1'b1; A = 4'd7; B = 4'd9;
    tick();
    for (int i = 0; i < 5; i++) begin
      A = 4'(i + 2); B = 4'(i + 5);
      tick();
    end
    checkOutput("heldStartDone", int'(DONE), 1);
    checkOutput("heldStartP", int'(P), 63);
    A = 4'd2; B = 4'd3;
    tick();
    START = 1'b0;
    checkOutput("nextStartBusy", int'(BUSY), 1);
    waitDone(calc);
    checkOutput("nextStartP", int'(P), 6);

    // Reset on the second CALC cycle abandons the product
    START = 1'b1; A = 4'd5; B = 4'd6;
    tick();
    START = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("abortBusy", int'(BUSY), 0);
    checkOutput("abortP", int'(P), 0);
    calc = 0;
    for (int i = 0; i < 8; i++) begin
      if (DONE) calc++;
      tick();
    end
    checkOutput("abortNoDone", calc, 0);
    applyStimulus(4'd3, 4'd4, 12);

    // Reset and START together: reset wins
    RST = 1'b1; START = 1'b1; A = 4'd2; B = 4'd2;
    tick();
    RST = 1'b0; START = 1'b0;
    checkOutput("rstWinsBusy", int'(BUSY), 0);
    tick();
    checkOutput("rstWinsStillIdle", int'(BUSY), 0);

    // Zero multiplier: 1 CALC cycle with early termination, 4 without
    applyStimulus(4'd9, 4'd0, 0);
    applyStimulus(4'd3, 4'd2, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/seq_mult4.md
Name: seq_mult4

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier.
- Sits directly upstream of the 4-bit ripple-carry adder ADDER4_2. It drives the adder's A, B and Cin once per cycle and consumes its S and Cout.
- Gives the datapath an 8-bit product using one shared 4-bit adder instead of an array multiplier.

Parameters:
- DONE_PULSE, 1: 1 means DONE is high for exactly one cycle. 0 means DONE stays high from completion until the next accepted START.

Ports:
- CLK      input   1  Clock; all state changes on the rising edge.
- RST      input   1  Synchronous, active-high reset.
- START    input   1  Request; sampled only while not BUSY.
- A        input   4  Multiplicand; captured when START is accepted.
- B        input   4  Multiplier; captured when START is accepted.
- BUSY     output  1  High while a multiplication is in progress.
- DONE     output  1  Completion strobe or level (see DONE_PULSE).
- P        output  8  Product; valid when DONE is high, held until the next START is accepted.

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE, BUSY=0, DONE=0, P=0, internal registers cleared. Reset mid-operation abandons the calculation with no DONE.
- Internal registers:
  - MCAND[3:0] holds the multiplicand.
  - ACC[8:0] holds the 9-bit running result: {carry, high nibble, low nibble}.
  - CNT[1:0] counts iterations.
- FSM states:
  - IDLE: if START=1, load MCAND=A, ACC={5'b0,B}, CNT=0, then go to CALC and set BUSY=1 on the next cycle.
  - CALC: one iteration per cycle.
    - Adder inputs: A = ACC[7:4], B = (ACC[0] ? MCAND : 4'b0), Cin = 0.
    - Next ACC = {1'b0, Cout, S, ACC[3:1]}, i.e. a logical right shift of {Cout,S,ACC[3:0]}.
    - CNT increments each cycle. When CNT==3, go to FIN.
  - FIN: P = ACC[7:0], DONE=1, BUSY=0. Next state is IDLE.
- Latency: START accepted at edge N gives DONE=1 and a valid P in the cycle after edge N+5. There are four CALC cycles. Throughput is one product per 6 cycles.
- START is ignored while BUSY=1 or in FIN. A, B and START changing mid-operation have no effect.
- With DONE_PULSE=0: DONE stays high in IDLE until a START is accepted, and clears on that same edge.
- P holds its last value through IDLE. It changes only on reset or at the next FIN.
- Arithmetic:
  - Unsigned only. The maximum is 15*15 = 225, which fits in 8 bits, so no overflow is possible.
  - ACC[8] is always 0 after each shift.
- Simultaneous RST and START: RST wins.

Optional Feature:
- Macro: SEQ_MULT4_EARLY_TERM_EN.
- Defined:
  - In CALC, if the remaining multiplier bits ACC[3:0] shifted by the remaining iteration count are all zero, finish early.
  - Concretely: if (ACC[3:0] >> 0) under the remaining mask is all zero, perform the pending shifts in one step and go to FIN.
  - B=0 completes after 1 CALC cycle. Result values are identical to the non-early-termination build.
- Undefined: fixed 4 CALC cycles. Latency is constant.

Decomposition:
- Package seq_mult4_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, FIN} state_t
  - localparam N_ITER = 4
  - localparam P_W = 8
- Sub-module: one instance of ADDER4_2 for the per-cycle add. No other sub-modules. The FSM and shift register stay in seq_mult4.

Test Plan:
- Reset then idle: RST high 2 cycles -> BUSY=0, DONE=0, P=8'h00; no change with START=0 for 10 cycles.
- A=4'd13, B=4'd11, START 1 cycle -> BUSY high 4 cycles, DONE high 6th cycle after acceptance, P=8'd143.
- Exhaustive: all 256 (A,B) pairs back-to-back, START asserted on each IDLE cycle -> P==A*B every time; max case 15*15 -> P=8'd225.
- START held high while BUSY with changing A/B -> ignored; A=7, B=9 gives P=8'd63; next product starts only after FIN.
- RST asserted on the 2nd CALC cycle of A=5, B=6 -> no DONE; P stays at its previous value reset to 0; a new START A=3, B=4 gives P=8'd12.
- Feature: with SEQ_MULT4_EARLY_TERM_EN, A=9, B=0 -> DONE after 1 CALC cycle, P=0. Without it -> 4 CALC cycles, P=0. Check DONE_PULSE=0 holds DONE until the next START.
